// File: rtl/sram_controller.sv
// sram_controller: bridges one 32-bit load/store from the MEM stage onto a
// 16-bit asynchronous SRAM as two half-word transfers. Each accepted access
// runs IDLE -> S1 -> S2 -> S3 -> S4 -> DONE -> IDLE. ready drops for the five
// busy cycles and freezes the pipeline during that time.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   wr_en, rd_en   store / load request (a store wins when both are set)
//   address        byte address (ALU result); the data window starts at 1024
//   write_data     store data
//   read_data      assembled load word, registered
//   ready          combinational access-complete / pipeline-run flag
//   SRAM_ADDR      half-word address to the SRAM
//   SRAM_DQ        bidirectional SRAM data bus
//   SRAM_WE_N      active-low write strobe
//   SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N   tied low
module sram_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    localparam int unsigned WORD_IDX_W = 17;
    localparam int unsigned HALF_W     = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        S4   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t                  r_state;
    logic                    r_is_wr;
    logic [WORD_IDX_W-1:0]   r_word_idx;
    logic [HALF_W-1:0]       r_wdata_hi;
    logic [17:0]             r_addr;
    logic [31:0]             r_read_data;

    logic                    w_req;
    logic                    w_start;
    logic                    w_in_s1;
    logic                    w_drive;
    logic [WORD_IDX_W-1:0]   w_word_idx;
    logic [HALF_W-1:0]       w_dq_out;

    // Word index relative to the 1024-byte base; lower addresses wrap silently.
    assign w_word_idx = WORD_IDX_W'((address - 32'd1024) >> 2);

    // The SRAM side is gated by rst so nothing is written while in reset.
    assign w_req   = wr_en | rd_en;
    assign w_start = !rst && (r_state == IDLE) && w_req;
    assign w_in_s1 = !rst && (r_state == S1);

    // Low half goes out in the accepting IDLE cycle, high half in S1; the bus
    // otherwise parks on the last address driven.
    assign SRAM_ADDR = w_start ? {w_word_idx, 1'b0} :
                       w_in_s1 ? {r_word_idx, 1'b1} : r_addr;

    assign w_drive   = (w_start && wr_en) || (w_in_s1 && r_is_wr);
    assign w_dq_out  = w_start ? write_data[15:0] : r_wdata_hi;
    assign SRAM_DQ   = w_drive ? w_dq_out : {HALF_W{1'bz}};
    assign SRAM_WE_N = !w_drive;

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    // During reset the state is treated as IDLE.
    assign ready = (rst || (r_state == IDLE)) ? !w_req : (r_state == DONE);

    assign read_data = r_read_data;

    // Access sequencer: latches the request in IDLE and captures read halves.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_is_wr     <= 1'b0;
            r_word_idx  <= '0;
            r_wdata_hi  <= '0;
            r_addr      <= '0;
            r_read_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_state    <= S1;
                        r_is_wr    <= wr_en;
                        r_word_idx <= w_word_idx;
                        r_wdata_hi <= write_data[31:16];
                        r_addr     <= {w_word_idx, 1'b0};
                        if (!wr_en) begin
                            r_read_data[15:0] <= SRAM_DQ;
                        end
                    end
                end
                S1: begin
                    r_state <= S2;
                    r_addr  <= {r_word_idx, 1'b1};
                    if (!r_is_wr) begin
                        r_read_data[31:16] <= SRAM_DQ;
                    end
                end
                S2:      r_state <= S3;
                S3:      r_state <= S4;
                S4:      r_state <= DONE;
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: self-checking bench for sram_controller. A behavioural
// 16-bit asynchronous SRAM sits on the bus; every access pushes its expected
// read_data onto a scoreboard queue that is popped in the DONE cycle.
module tb_sram_controller;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    wire  [15:0] SRAM_DQ;
    logic        SRAM_WE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] sram [0:262143];
    logic [31:0] ref_mem [int];
    logic [31:0] exp_q [$];
    logic [31:0] last_rd = 32'h0;

    sram_controller dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_DQ    (SRAM_DQ),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_UB_N  (SRAM_UB_N),
        .SRAM_LB_N  (SRAM_LB_N),
        .SRAM_CE_N  (SRAM_CE_N),
        .SRAM_OE_N  (SRAM_OE_N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read SRAM; writes land at the rising edge while WE_N is low.
    assign SRAM_DQ = SRAM_WE_N ? sram[SRAM_ADDR] : 16'hzzzz;
    always @(posedge clk) begin
        if (!SRAM_WE_N) sram[SRAM_ADDR] <= SRAM_DQ;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full access. Starts at a negedge in IDLE, or in DONE when from_done
    // is set; returns just after the negedge of the DONE cycle.
    task automatic run_access(input logic wr, input logic rd, input logic [31:0] addr,
                              input logic [31:0] data, input logic [17:0] exp_lo,
                              input bit from_done);
        int lo;
        logic [31:0] exp;
        wr_en      = wr;
        rd_en      = rd;
        address    = addr;
        write_data = data;
        if (from_done) begin
            #1 chk("b2b_done_rdy", 32'(ready), 32'd1);
            @(negedge clk);
        end
        if (wr) begin
            ref_mem[int'(exp_lo)] = data;
            exp_q.push_back(last_rd);
        end else begin
            exp_q.push_back(ref_mem.exists(int'(exp_lo)) ? ref_mem[int'(exp_lo)] : 32'h0);
        end
        #1;
        chk("req_rdy", 32'(ready), 32'd0);
        chk("addr_lo", 32'(SRAM_ADDR), 32'(exp_lo));
        chk("we_lo", 32'(SRAM_WE_N), 32'(!wr));
        if (wr) chk("dq_lo", 32'(SRAM_DQ), 32'(data[15:0]));
        @(negedge clk);
        // Scramble inputs after acceptance; the access must not notice.
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        address    = 32'h0;
        write_data = ~data;
        #1;
        chk("addr_hi", 32'(SRAM_ADDR), 32'(exp_lo | 18'd1));
        chk("we_hi", 32'(SRAM_WE_N), 32'(!wr));
        if (wr) chk("dq_hi", 32'(SRAM_DQ), 32'(data[31:16]));
        lo = 2;
        @(negedge clk);
        #1;
        while (ready == 1'b0 && lo < 20) begin
            chk("we_busy", 32'(SRAM_WE_N), 32'd1);
            chk("addr_hold", 32'(SRAM_ADDR), 32'(exp_lo | 18'd1));
            lo++;
            @(negedge clk);
            #1;
        end
        chk("lo_cycles", 32'(lo), 32'd5);
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            chk("rdata", read_data, exp);
            last_rd = exp;
        end
    endtask

    initial begin
        rst        = 1'b1;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        address    = 32'h0;
        write_data = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rdata", read_data, 32'h0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_we", 32'(SRAM_WE_N), 32'd1);
        chk("rst_addr", 32'(SRAM_ADDR), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Write then read at the base of the window.
        @(negedge clk);
        run_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 18'h0, 1'b0);
        chk("sram0", 32'(sram[0]), 32'h0000BEEF);
        chk("sram1", 32'(sram[1]), 32'h0000DEAD);
        @(negedge clk);
        run_access(1'b0, 1'b1, 32'd1024, 32'h0, 18'h0, 1'b0);

        // Back-to-back write then read with a single DONE gap.
        @(negedge clk);
        run_access(1'b1, 1'b0, 32'd1028, 32'h12345678, 18'h2, 1'b0);
        run_access(1'b0, 1'b1, 32'd1028, 32'h0, 18'h2, 1'b1);

        // Simultaneous enables behave as a write.
        @(negedge clk);
        run_access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 18'h4, 1'b0);
        chk("sram4", 32'(sram[4]), 32'h0000F00D);
        chk("sram5", 32'(sram[5]), 32'h0000CAFE);

        // Address below the window wraps to the top of the SRAM.
        @(negedge clk);
        run_access(1'b1, 1'b0, 32'd0, 32'hA5A55A5A, 18'h3FE00, 1'b0);
        @(negedge clk);
        run_access(1'b0, 1'b1, 32'd0, 32'h0, 18'h3FE00, 1'b0);

        // Reset in S2 of a read abandons it.
        @(negedge clk);
        rd_en   = 1'b1;
        address = 32'd1024;
        @(negedge clk);
        rd_en   = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_rdata", read_data, 32'h0);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_we", 32'(SRAM_WE_N), 32'd1);
        chk("mid_rst_addr", 32'(SRAM_ADDR), 32'h0);
        last_rd = 32'h0;
        @(negedge clk);
        run_access(1'b0, 1'b1, 32'd1028, 32'h0, 18'h2, 1'b0);

        @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, with the ports listed first: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 wr_en  input  1  Write request from the EXE->MEM pipeline register.
REQ-003 rd_en  input  1  Read request from the EXE->MEM pipeline register.
REQ-004 address  input  32  Byte address, equal to the ALU result.
REQ-005 write_data  input  32  Store data, equal to the forwarded Rm value.
REQ-006 read_data  output  32  Assembled load word, registered.
REQ-007 ready  output  1  Access complete. When ready=0 the pipeline freezes every stage.
REQ-008 SRAM_ADDR  output  18  External SRAM half-word address.
REQ-009 SRAM_DQ  inout  16  External SRAM data bus.
REQ-010 SRAM_WE_N  output  1  Active-low write strobe.
REQ-011 SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  output  1 each  All SHALL be tied to 0.

Function
REQ-012 word_idx SHALL equal ((address - 1024) >> 2) truncated to 17 bits. Addresses below 1024 SHALL wrap modulo 2^17 words, with no error flagged.
REQ-013 The half-word addresses SHALL be: low half = {word_idx,1'b0}; high half = {word_idx,1'b1}. Data SHALL be little-endian: the low half holds bits [15:0].
REQ-014 The FSM SHALL have the states IDLE, S1, S2, S3, S4, DONE.
REQ-015 IDLE SHALL move to S1 when (wr_en | rd_en) is 1; otherwise it SHALL remain in IDLE.
REQ-016 S1 SHALL move to S2, S2 to S3, S3 to S4, S4 to DONE, and DONE to IDLE, each unconditionally.
REQ-017 The request SHALL be sampled only in IDLE. Changes to enable, address or data after acceptance SHALL be ignored until the access returns to IDLE.
REQ-018 If wr_en and rd_en are both 1, the access SHALL be a write, and read_data SHALL be unchanged.
REQ-019 In the cycles "IDLE with request" and S1:
- SRAM_ADDR SHALL be the low half-word address and then the high half-word address, respectively.
- In all other cycles SRAM_ADDR SHALL hold the last driven value.
REQ-020 Write: SRAM_WE_N SHALL be 0 and SRAM_DQ SHALL be driven in the "IDLE with request" cycle (write_data[15:0]) and in S1 (write_data[31:16]) only.
REQ-021 In every other cycle SRAM_WE_N SHALL be 1 and SRAM_DQ SHALL be high-Z.
REQ-022 Read: read_data[15:0] SHALL be captured from SRAM_DQ at the edge that ends the "IDLE with request" cycle.
REQ-023 Read: read_data[31:16] SHALL be captured at the edge that ends S1.
REQ-024 read_data SHALL hold its value until the next read overwrites it.
REQ-025 ready SHALL be combinational and SHALL equal 1 when (state==IDLE and no request) or state==DONE; it SHALL be 0 otherwise.
REQ-026 An accepted access SHALL keep ready at 0 for exactly 5 cycles (IDLE-request, S1 to S4). ready SHALL be 1 in DONE.
REQ-027 Back-to-back accesses: DONE SHALL always pass through IDLE. A new request present in IDLE SHALL start immediately, adding no bubble cycles beyond the single DONE cycle.
REQ-028 read_data bits in write-only accesses SHALL be untouched.

Reset
REQ-029 When rst=1 at a rising edge, the following SHALL hold in any state, including mid-access:
- state = IDLE
- read_data = 0
- SRAM_ADDR = 0
- SRAM_WE_N = 1
- SRAM_DQ = high-Z
REQ-030 An access interrupted by reset SHALL be abandoned, not resumed. A write interrupted after its S1 half SHALL leave both halves as already written.
REQ-031 While rst=1, ready SHALL follow REQ-025 with state=IDLE.

Verification
REQ-032 Write 0xDEADBEEF at address 1024 -> SRAM model [0]=0xBEEF and [1]=0xDEAD; ready low for exactly 5 cycles, then high for one DONE cycle.
REQ-033 Read at address 1024 after REQ-032 -> read_data = 0xDEADBEEF in DONE; SRAM_WE_N stays 1 throughout.
REQ-034 Write 0x12345678 at 1028 followed directly by a read at 1028 -> SRAM_ADDR 2 then 3; read returns 0x12345678; exactly one ready-high cycle between the two accesses.
REQ-035 rd_en=wr_en=1 at 1032 with data 0xCAFEF00D -> SRAM [4]=0xF00D and [5]=0xCAFE; read_data unchanged.
REQ-036 rst asserted in S2 of a read -> next cycle state=IDLE, read_data=0, ready=1 (no request); a subsequent read completes normally.
REQ-037 Write at address 0 -> word_idx wraps to 0x1FF00; SRAM_ADDR = 0x3FE00 and then 0x3FE01.
